// File: rtl/minsoc_rst_seq_pkg.sv
// Purpose: shared state encodings and default timing values for the reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minsoc_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } rst_state_t;

    localparam int DEF_PLL_RST_CYCLES     = 8;
    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 256;
    localparam int DEF_RST_HOLD_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT       = 65536;

    // Largest of four counts; sizes the single shared state counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/minsoc_sync_bit.sv
// Purpose: N-stage single-bit synchronizer, flops clear to 0 on async active-high rst.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; q simply follows d.
// Ports: clk, rst (async, active-high), d (async input), q (synchronized output).
module minsoc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/minsoc_rst_seq.sv
// Purpose: PLL restart / lock qualification / system reset release sequencer on the reference clock.
// Latency: lock change seen SYNC_STAGES cycles late, state and all outputs move one edge after that.
// Backpressure: none; soft_rst_req is a single-cycle request that is always accepted.
// Ports: clk, reset (async active-high), pll_locked (async), soft_rst_req -> pll_areset, sys_rst,
//        rst_ready (high only in RUN), relock_count (saturating lock-loss/timeout count).
module minsoc_rst_seq
    import minsoc_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_areset,
    output logic       sys_rst,
    output logic       rst_ready,
    output logic [7:0] relock_count
);

    localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, LOCK_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter starts at 0 on the entry edge, so the last cycle of an N-cycle state sees N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    rst_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             relock_inc;
    logic             locked_s;

    minsoc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        relock_inc = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle wins over the restart.
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt  = ST_PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                // A glitch before qualification is not counted as a relock.
                if (!locked_s)                state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_nxt  = ST_PLL_RST;
                    relock_inc = 1'b1;
                end else if (soft_rst_req) begin
                    cnt_clr = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_nxt  = ST_PLL_RST;
                    relock_inc = 1'b1;
                end else if (soft_rst_req) begin
                    state_nxt = ST_HOLD;
                end
            end
            default: state_nxt = ST_PLL_RST;
        endcase
        if (state_nxt != state) cnt_clr = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            relock_count <= 8'd0;
            pll_areset   <= 1'b1;
            sys_rst      <= 1'b1;
            rst_ready    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state != ST_RUN) begin
                // RUN has no timed exit, so its count is frozen rather than left to wrap.
                cnt <= cnt + CNT_W'(1);
            end
            if (relock_inc && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
            // Outputs decode the next state so they switch on the same edge as the state.
            pll_areset <= (state_nxt == ST_PLL_RST);
            sys_rst    <= (state_nxt != ST_RUN);
            rst_ready  <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_minsoc_rst_seq.sv
module tb_minsoc_rst_seq;

    localparam int P_RST = 4;
    localparam int SYNC  = 2;
    localparam int STAB  = 8;
    localparam int HOLDC = 4;
    localparam int TMO   = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_areset;
    logic       sys_rst;
    logic       rst_ready;
    logic [7:0] relock_count;

    int cyc = 0;
    int base = 0;
    int n_tests = 0;
    int n_fail = 0;
    int areset_hits = 0;
    int exp_q[$];

    minsoc_rst_seq #(
        .PLL_RST_CYCLES     (P_RST),
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (STAB),
        .RST_HOLD_CYCLES    (HOLDC),
        .LOCK_TIMEOUT       (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_areset   (pll_areset),
        .sys_rst      (sys_rst),
        .rst_ready    (rst_ready),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (pll_areset === 1'b1) areset_hits++;

    function automatic logic sig(input int which);
        case (which)
            0:       return pll_areset;
            1:       return sys_rst;
            default: return rst_ready;
        endcase
    endfunction

    // Edge number (relative to reset release) at which a signal first takes val; -1 on timeout.
    task automatic wait_for(input int which, input logic val, input int budget, output int edge_n);
        edge_n = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sig(which) === val) begin
                edge_n = cyc - base;
                return;
            end
        end
    endtask

    task automatic go_to(input int k);
        while (cyc - base < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input logic lk);
        reset = 1'b1;
        pll_locked = lk;
        soft_rst_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        base = cyc;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        n_tests++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL reset_pll_areset: got %b expected 1", pll_areset); end
        n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
        n_tests++; if (rst_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rst_ready: got %b expected 0", rst_ready); end
        n_tests++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL reset_relock_count: got %0d expected 0", relock_count); end
    endtask

    task automatic test_bringup;
        int e, x;
        do_reset(1'b1);
        exp_q.push_back(P_RST);
        exp_q.push_back(P_RST + 1 + STAB + HOLDC);
        wait_for(0, 1'b0, 50, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL bringup_areset_fall: got edge %0d expected %0d", e, x); end
        wait_for(1, 1'b0, 50, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL bringup_sys_rst_fall: got edge %0d expected %0d", e, x); end
        n_tests++; if (rst_ready !== 1'b1) begin n_fail++; $display("FAIL bringup_rst_ready: got %b expected 1", rst_ready); end
        n_tests++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL bringup_relock: got %0d expected 0", relock_count); end
    endtask

    task automatic test_lock_glitch;
        int e, x;
        do_reset(1'b1);
        go_to(7);
        areset_hits = 0;
        pll_locked = 1'b0;
        go_to(10);
        pll_locked = 1'b1;
        // STABLE re-entered SYNC+1 edges after lock returns, then full stable + hold.
        exp_q.push_back(10 + SYNC + 1 + STAB + HOLDC);
        wait_for(1, 1'b0, 40, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL glitch_release: got edge %0d expected %0d", e, x); end
        n_tests++; if (areset_hits !== 0) begin n_fail++; $display("FAIL glitch_no_pll_rst: got %0d areset cycles expected 0", areset_hits); end
        n_tests++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL glitch_relock: got %0d expected 0", relock_count); end
    endtask

    task automatic test_soft_reset;
        int e, x;
        do_reset(1'b1);
        go_to(20);
        areset_hits = 0;
        soft_rst_req = 1'b1;
        exp_q.push_back(21);
        exp_q.push_back(21 + HOLDC);
        @(posedge clk); #1;
        soft_rst_req = 1'b0;
        e = (sys_rst === 1'b1) ? cyc - base : -1; x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL soft_sys_rst_rise: got edge %0d expected %0d", e, x); end
        wait_for(1, 1'b0, 20, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL soft_sys_rst_fall: got edge %0d expected %0d", e, x); end
        // Second request enters HOLD at 31; a re-request sampled at 33 restarts the hold.
        go_to(30);
        soft_rst_req = 1'b1;
        @(posedge clk); #1;
        soft_rst_req = 1'b0;
        go_to(32);
        soft_rst_req = 1'b1;
        exp_q.push_back(33 + HOLDC);
        @(posedge clk); #1;
        soft_rst_req = 1'b0;
        wait_for(1, 1'b0, 20, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL soft_hold_extend: got edge %0d expected %0d", e, x); end
        n_tests++; if (areset_hits !== 0) begin n_fail++; $display("FAIL soft_pll_untouched: got %0d areset cycles expected 0", areset_hits); end
        n_tests++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL soft_relock: got %0d expected 0", relock_count); end
    endtask

    task automatic test_lock_loss_run;
        int e, x;
        do_reset(1'b1);
        go_to(20);
        pll_locked = 1'b0;
        exp_q.push_back(20 + SYNC + 1);
        exp_q.push_back(20 + SYNC + 1 + P_RST);
        exp_q.push_back(20 + SYNC + 1 + P_RST + 1 + STAB + HOLDC);
        wait_for(1, 1'b1, 10, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL loss_sys_rst_rise: got edge %0d expected %0d", e, x); end
        n_tests++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL loss_areset_rise: got %b expected 1", pll_areset); end
        go_to(24);
        pll_locked = 1'b1;
        wait_for(0, 1'b0, 10, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL loss_areset_fall: got edge %0d expected %0d", e, x); end
        n_tests++; if (relock_count !== 8'd1) begin n_fail++; $display("FAIL loss_relock: got %0d expected 1", relock_count); end
        wait_for(1, 1'b0, 30, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL loss_release: got edge %0d expected %0d", e, x); end
    endtask

    // Entered while in RUN with relock_count=1; reset must clear everything without a clock edge.
    task automatic test_async_reset;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        n_tests++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL async_pll_areset: got %b expected 1", pll_areset); end
        n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL async_sys_rst: got %b expected 1", sys_rst); end
        n_tests++; if (rst_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 0", rst_ready); end
        n_tests++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL async_relock: got %0d expected 0", relock_count); end
    endtask

    task automatic test_coincident;
        int e, x;
        do_reset(1'b1);
        go_to(20);
        pll_locked = 1'b0;
        go_to(22);
        soft_rst_req = 1'b1;
        exp_q.push_back(23);
        @(posedge clk); #1;
        soft_rst_req = 1'b0;
        e = (pll_areset === 1'b1) ? cyc - base : -1; x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL coincident_pll_rst: got edge %0d expected %0d", e, x); end
        n_tests++; if (relock_count !== 8'd1) begin n_fail++; $display("FAIL coincident_relock: got %0d expected 1", relock_count); end
        pll_locked = 1'b1;
    endtask

    task automatic test_never_lock;
        int e, x;
        do_reset(1'b0);
        exp_q.push_back(P_RST);
        wait_for(0, 1'b0, 10, e); x = exp_q.pop_front();
        n_tests++; if (e !== x) begin n_fail++; $display("FAIL nolock_first_fall: got edge %0d expected %0d", e, x); end
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(k * (P_RST + TMO));
            exp_q.push_back(k * (P_RST + TMO) + P_RST);
            wait_for(0, 1'b1, 40, e); x = exp_q.pop_front();
            n_tests++; if (e !== x) begin n_fail++; $display("FAIL nolock_rise_%0d: got edge %0d expected %0d", k, e, x); end
            n_tests++; if (relock_count !== 8'(k)) begin n_fail++; $display("FAIL nolock_count_%0d: got %0d expected %0d", k, relock_count, k); end
            wait_for(0, 1'b0, 10, e); x = exp_q.pop_front();
            n_tests++; if (e !== x) begin n_fail++; $display("FAIL nolock_fall_%0d: got edge %0d expected %0d", k, e, x); end
        end
        go_to(254 * (P_RST + TMO));
        n_tests++; if (relock_count !== 8'd254) begin n_fail++; $display("FAIL nolock_count_254: got %0d expected 254", relock_count); end
        go_to(255 * (P_RST + TMO));
        n_tests++; if (relock_count !== 8'd255) begin n_fail++; $display("FAIL nolock_count_255: got %0d expected 255", relock_count); end
        go_to(257 * (P_RST + TMO) + 1);
        n_tests++; if (relock_count !== 8'd255) begin n_fail++; $display("FAIL nolock_saturate: got %0d expected 255", relock_count); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_glitch();
        test_soft_reset();
        test_lock_loss_run();
        test_async_reset();
        test_coincident();
        test_never_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
